// File: rtl/score_bcd_converter_pkg.sv
// rtl/score_bcd_converter_pkg.sv - shared constants and state encoding for the score BCD converter
package score_bcd_converter_pkg;

  localparam int DEF_WIDTH     = 13;
  localparam int DEF_DIGITS    = 4;
  localparam int DEF_MAX_VALUE = 9999;

  // One BCD nine; replicated per digit to form the saturation pattern.
  localparam logic [3:0] NINE_DIGIT = 4'h9;
  localparam logic [4*DEF_DIGITS-1:0] SAT_BCD = {DEF_DIGITS{NINE_DIGIT}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/score_bcd_converter_if.sv
// rtl/score_bcd_converter_if.sv - request/result bundle between score read port and display decoders
interface score_bcd_converter_if #(
  parameter int WIDTH  = 13,
  parameter int DIGITS = 4
);

  logic                  Start;
  logic [WIDTH-1:0]      BinIn;
  logic                  Busy;
  logic                  Done;
  logic                  Valid;
  logic [4*DIGITS-1:0]   Bcd;
  logic                  Overflow;

  modport master (
    output Start, BinIn,
    input  Busy, Done, Valid, Bcd, Overflow
  );

  modport slave (
    input  Start, BinIn,
    output Busy, Done, Valid, Bcd, Overflow
  );

endinterface

// File: rtl/score_bcd_converter_bcd_digit_adjust.sv
// rtl/score_bcd_converter_bcd_digit_adjust.sv - add-3 correction for one BCD digit before a shift
module bcd_digit_adjust (
  input  logic [3:0] digitIn,
  output logic [3:0] digitOut
);

  // A digit of 5..9 would become >= 10 after doubling, so pre-add 3 to carry into the next digit.
  assign digitOut = (digitIn >= 4'd5) ? (digitIn + 4'd3) : digitIn;

endmodule

// File: rtl/score_bcd_converter.sv
// rtl/score_bcd_converter.sv - sequential double-dabble binary to BCD converter with saturation
module score_bcd_converter
  import score_bcd_converter_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int DIGITS    = DEF_DIGITS,
  parameter int MAX_VALUE = DEF_MAX_VALUE
) (
  input  logic                  Clock,
  input  logic                  CLRN,
  score_bcd_converter_if.slave  bus
);

  localparam int SW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);
  localparam logic [31:0]   MAX_U     = 32'(MAX_VALUE);

  state_t          state;
  state_t          nextState;
  logic [WIDTH-1:0] binReg;
  logic [SW-1:0]   scratch;
  logic [SW-1:0]   adjusted;
  logic [SW-1:0]   shiftedScratch;
  logic [CW-1:0]   count;
  logic            ovfPending;
  logic [SW-1:0]   bcdReg;
  logic            ovfReg;
  logic            validReg;
  logic            busyOut;
  logic            doneOut;
  logic            lastIter;

  for (genvar d = 0; d < DIGITS; d++) begin : gAdjust
    bcd_digit_adjust uAdjust (
      .digitIn  (scratch[4*d +: 4]),
      .digitOut (adjusted[4*d +: 4])
    );
  end

  // Carry out of the top digit is dropped; it only occurs for inputs that saturate anyway.
  assign shiftedScratch = {adjusted[SW-2:0], binReg[WIDTH-1]};
  assign lastIter       = (count == LAST_ITER);

  // State register.
  always_ff @(posedge Clock or negedge CLRN) begin
    if (!CLRN) state <= IDLE;
    else       state <= nextState;
  end

  // Next-state: one conversion per accepted Start, DONE lasts a single cycle.
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (bus.Start) nextState = SHIFT;
      SHIFT:   if (lastIter)  nextState = DONE;
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Handshake outputs decoded from the current state.
  always_comb begin
    busyOut = 1'b0;
    doneOut = 1'b0;
    case (state)
      SHIFT:   busyOut = 1'b1;
      DONE:    doneOut = 1'b1;
      default: ;
    endcase
  end

  // Datapath: capture on accept, one add-3/shift per SHIFT cycle, publish result on the last one.
  always_ff @(posedge Clock or negedge CLRN) begin
    if (!CLRN) begin
      binReg     <= '0;
      scratch    <= '0;
      count      <= '0;
      ovfPending <= 1'b0;
      bcdReg     <= '0;
      ovfReg     <= 1'b0;
      validReg   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.Start) begin
            binReg     <= bus.BinIn;
            scratch    <= '0;
            count      <= '0;
            ovfPending <= (32'(bus.BinIn) > MAX_U);
          end
        end
        SHIFT: begin
          scratch <= shiftedScratch;
          binReg  <= {binReg[WIDTH-2:0], 1'b0};
          count   <= count + CW'(1);
          if (lastIter) begin
            bcdReg   <= ovfPending ? {DIGITS{NINE_DIGIT}} : shiftedScratch;
            ovfReg   <= ovfPending;
            validReg <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.Busy     = busyOut;
  assign bus.Done     = doneOut;
  assign bus.Valid    = validReg;
  assign bus.Bcd      = bcdReg;
  assign bus.Overflow = ovfReg;

endmodule
